// File: rtl/enigma_pkg.sv
// Shared Enigma datapath definitions: letter encoding, rotor wiring tables
// (forward and derived inverse) and the mod-26 helper used by every stage.
package enigma_pkg;

    localparam int LETTER_W = 6;
    localparam int ALPHA    = 26;
    localparam int N_ROTORS = 5;

    typedef logic [LETTER_W-1:0] letter_t;

    typedef enum logic [2:0] {
        ROTOR_I   = 3'd0,
        ROTOR_II  = 3'd1,
        ROTOR_III = 3'd2,
        ROTOR_IV  = 3'd3,
        ROTOR_V   = 3'd4
    } rotor_sel_e;

    // Ascending ranges so the concatenation below reads rotor I first, contact A first.
    typedef logic [0:N_ROTORS-1][0:ALPHA-1][LETTER_W-1:0] wiring_t;

    localparam logic [LETTER_W:0] ALPHA_X = (LETTER_W+1)'(ALPHA);

    localparam wiring_t FWD_WIRING = {
        // I   EKMFLGDQVZNTOWYHXUSPAIBRCJ
        6'd4,  6'd10, 6'd12, 6'd5,  6'd11, 6'd6,  6'd3,  6'd16, 6'd21, 6'd25, 6'd13, 6'd19, 6'd14,
        6'd22, 6'd24, 6'd7,  6'd23, 6'd20, 6'd18, 6'd15, 6'd0,  6'd8,  6'd1,  6'd17, 6'd2,  6'd9,
        // II  AJDKSIRUXBLHWTMCQGZNPYFVOE
        6'd0,  6'd9,  6'd3,  6'd10, 6'd18, 6'd8,  6'd17, 6'd20, 6'd23, 6'd1,  6'd11, 6'd7,  6'd22,
        6'd19, 6'd12, 6'd2,  6'd16, 6'd6,  6'd25, 6'd13, 6'd15, 6'd24, 6'd5,  6'd21, 6'd14, 6'd4,
        // III BDFHJLCPRTXVZNYEAIOUQSGKMW
        6'd1,  6'd3,  6'd5,  6'd7,  6'd9,  6'd11, 6'd2,  6'd15, 6'd17, 6'd19, 6'd23, 6'd21, 6'd25,
        6'd13, 6'd24, 6'd4,  6'd0,  6'd8,  6'd14, 6'd20, 6'd16, 6'd18, 6'd6,  6'd10, 6'd12, 6'd22,
        // IV  ESOVPZJAYQUIRHXLNFTGKDCMWB
        6'd4,  6'd18, 6'd14, 6'd21, 6'd15, 6'd25, 6'd9,  6'd0,  6'd24, 6'd16, 6'd20, 6'd8,  6'd17,
        6'd7,  6'd23, 6'd11, 6'd13, 6'd5,  6'd19, 6'd6,  6'd10, 6'd3,  6'd2,  6'd12, 6'd22, 6'd1,
        // V   VZBRGITYUPSDNHLXAWMJQOFECK
        6'd21, 6'd25, 6'd1,  6'd17, 6'd6,  6'd8,  6'd19, 6'd24, 6'd20, 6'd15, 6'd18, 6'd3,  6'd13,
        6'd7,  6'd11, 6'd23, 6'd0,  6'd22, 6'd12, 6'd9,  6'd16, 6'd14, 6'd5,  6'd4,  6'd2,  6'd10
    };

    function automatic wiring_t build_inv(input wiring_t fwd);
        wiring_t inv;
        inv = '0;
        for (int s = 0; s < N_ROTORS; s++)
            for (int i = 0; i < ALPHA; i++)
                inv[s][fwd[s][i][4:0]] = LETTER_W'(i);
        return inv;
    endfunction

    localparam wiring_t INV_WIRING = build_inv(FWD_WIRING);

    // Operands are expected in 0..25; one compare-and-subtract folds the result back.
    function automatic letter_t mod26_addsub(input letter_t a, input letter_t b, input logic sub);
        logic [LETTER_W:0] s;
        if (sub)
            s = {1'b0, a} + ALPHA_X - {1'b0, b};
        else
            s = {1'b0, a} + {1'b0, b};
        if (s >= ALPHA_X)
            s = s - ALPHA_X;
        return s[LETTER_W-1:0];
    endfunction

endpackage

// File: rtl/rotor_return_pipe_if.sv
// Valid/ready bundle between the reflector output and the return-side plugboard.
interface rotor_return_pipe_if;
    import enigma_pkg::*;

    logic    in_valid;
    logic    in_ready;
    letter_t in_letter;
    letter_t in_pos_l;
    letter_t in_pos_m;
    letter_t in_pos_r;
    logic    out_valid;
    logic    out_ready;
    letter_t out_letter;

    modport slave (
        input  in_valid, in_letter, in_pos_l, in_pos_m, in_pos_r, out_ready,
        output in_ready, out_valid, out_letter
    );

    modport master (
        output in_valid, in_letter, in_pos_l, in_pos_m, in_pos_r, out_ready,
        input  in_ready, out_valid, out_letter
    );

endinterface

// File: rtl/rotor_inv_stage.sv
// One registered inverse-rotor stage with valid/ready; carries the positions
// later stages need so each letter keeps its own rotor snapshot.
module rotor_inv_stage
    import enigma_pkg::*;
#(
    parameter rotor_sel_e SEL   = ROTOR_I,
    parameter int         FWD_W = LETTER_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  letter_t          in_letter,
    input  letter_t          in_pos,
    input  logic [FWD_W-1:0] in_fwd,
    output logic             out_valid,
    input  logic             out_ready,
    output letter_t          out_letter,
    output logic [FWD_W-1:0] out_fwd
);

    logic             valid_q, valid_d;
    letter_t          letter_q, letter_d;
    logic [FWD_W-1:0] fwd_q, fwd_d;
    letter_t          idx, wired, xform;
    logic             load;

    // Illegal positions can push idx past Z; map those to 0 rather than index off the table.
    always_comb begin
        idx   = mod26_addsub(in_letter, in_pos, 1'b0);
        wired = (idx < LETTER_W'(ALPHA)) ? INV_WIRING[SEL][idx[4:0]] : '0;
        xform = (in_letter < LETTER_W'(ALPHA)) ? mod26_addsub(wired, in_pos, 1'b1) : in_letter;
    end

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready;

    always_comb begin
        valid_d  = valid_q;
        letter_d = letter_q;
        fwd_d    = fwd_q;
        if (load) begin
            valid_d  = 1'b1;
            letter_d = xform;
            fwd_d    = in_fwd;
        end else if (out_ready) begin
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            letter_q <= '0;
            fwd_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            letter_q <= letter_d;
            fwd_q    <= fwd_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_letter = letter_q;
    assign out_fwd    = fwd_q;

endmodule

// File: rtl/rotor_return_pipe.sv
// Return path through the rotor stack: left, middle, then right rotor inverse,
// one registered stage each, with positions travelling alongside the letter.
module rotor_return_pipe
    import enigma_pkg::*;
#(
    parameter int ROTOR_L = 0,
    parameter int ROTOR_M = 1,
    parameter int ROTOR_R = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    rotor_return_pipe_if.slave  bus
);

    localparam int STAGES = 3;

    logic    [STAGES:0]       vld_pipe;
    logic    [STAGES:0]       rdy_pipe;
    letter_t [STAGES:0]       let_pipe;
    logic    [2*LETTER_W-1:0] s1_fwd;
    letter_t                  s2_fwd;
    logic                     unused_fwd;

    assign vld_pipe[0]      = bus.in_valid;
    assign let_pipe[0]      = bus.in_letter;
    assign rdy_pipe[STAGES] = bus.out_ready;

    // Held low through reset so nothing upstream sees a transfer before the pipe is live.
    assign bus.in_ready   = rst_n & rdy_pipe[0];
    assign bus.out_valid  = vld_pipe[STAGES];
    assign bus.out_letter = let_pipe[STAGES];

    rotor_inv_stage #(.SEL(rotor_sel_e'(ROTOR_L)), .FWD_W(2*LETTER_W)) u_s1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (vld_pipe[0]),
        .in_ready   (rdy_pipe[0]),
        .in_letter  (let_pipe[0]),
        .in_pos     (bus.in_pos_l),
        .in_fwd     ({bus.in_pos_m, bus.in_pos_r}),
        .out_valid  (vld_pipe[1]),
        .out_ready  (rdy_pipe[1]),
        .out_letter (let_pipe[1]),
        .out_fwd    (s1_fwd)
    );

    rotor_inv_stage #(.SEL(rotor_sel_e'(ROTOR_M)), .FWD_W(LETTER_W)) u_s2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (vld_pipe[1]),
        .in_ready   (rdy_pipe[1]),
        .in_letter  (let_pipe[1]),
        .in_pos     (s1_fwd[2*LETTER_W-1:LETTER_W]),
        .in_fwd     (s1_fwd[LETTER_W-1:0]),
        .out_valid  (vld_pipe[2]),
        .out_ready  (rdy_pipe[2]),
        .out_letter (let_pipe[2]),
        .out_fwd    (s2_fwd)
    );

    // Last stage has nothing to forward; its one-bit carry slot is left dangling.
    rotor_inv_stage #(.SEL(rotor_sel_e'(ROTOR_R)), .FWD_W(1)) u_s3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (vld_pipe[2]),
        .in_ready   (rdy_pipe[2]),
        .in_letter  (let_pipe[2]),
        .in_pos     (s2_fwd),
        .in_fwd     (1'b0),
        .out_valid  (vld_pipe[3]),
        .out_ready  (rdy_pipe[3]),
        .out_letter (let_pipe[3]),
        .out_fwd    (unused_fwd)
    );

endmodule

// File: tb/tb_rotor_return_pipe.sv
// Directed and randomized checks of the rotor return pipe against a string-table
// Enigma model with a scoreboard queue.
module tb_rotor_return_pipe;

    localparam int RL = 0;
    localparam int RM = 1;
    localparam int RR = 2;

    logic clk;
    logic rst_n;

    rotor_return_pipe_if bus ();

    rotor_return_pipe #(.ROTOR_L(RL), .ROTOR_M(RM), .ROTOR_R(RR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    string ROT [5] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ", "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                       "BDFHJLCPRTXVZNYEAIOUQSGKMW", "ESOVPZJAYQUIRHXLNFTGKDCMWB",
                       "VZBRGITYUPSDNHLXAWMJQOFECK"};

    typedef struct { int l; int c; } exp_t;
    exp_t q[$];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc_n    = 0;
    int n_out    = 0;
    int n_acc    = 0;
    bit chk_lat  = 0;
    logic [5:0] last_out;
    logic       s_ovld, s_irdy;
    logic [5:0] s_ol;

    function automatic int inv_of(input int sel, input int y);
        for (int i = 0; i < 26; i++)
            if (int'(ROT[sel][i]) - 65 == y) return i;
        return -1;
    endfunction

    function automatic int ref_out(input int x, input int pl, input int pm, input int pr);
        int pos [3];
        int sel [3];
        int y;
        if (x > 25) return x;
        pos = '{pl, pm, pr};
        sel = '{RL, RM, RR};
        for (int k = 0; k < 3; k++) begin
            y = inv_of(sel[k], (x + pos[k]) % 26);
            x = (y - pos[k] + 26) % 26;
        end
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1: drive, sample the pre-edge handshake, clock, score.
    task automatic cyc(input bit v, input int l, input int pl, input int pm, input int pr, input bit ordy);
        bit   acc;
        exp_t e;
        bus.in_valid  = v;
        bus.in_letter = 6'(l);
        bus.in_pos_l  = 6'(pl);
        bus.in_pos_m  = 6'(pm);
        bus.in_pos_r  = 6'(pr);
        bus.out_ready = ordy;
        #1;
        acc    = v && (bus.in_ready === 1'b1);
        s_ovld = bus.out_valid;
        s_ol   = bus.out_letter;
        s_irdy = bus.in_ready;
        @(posedge clk);
        if (s_ovld === 1'b1 && ordy) begin
            chk("sb_nonempty", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_letter", s_ol, e.l);
                if (chk_lat) chk("latency", cyc_n - e.c, 3);
            end
            last_out = s_ol;
            n_out++;
        end
        if (acc) begin
            q.push_back('{ref_out(l, pl, pm, pr), cyc_n});
            n_acc++;
        end
        cyc_n++;
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            cyc(0, 0, 0, 0, 0, 1);
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    function automatic int rp();
        return int'($urandom_range(0, 25));
    endfunction

    initial begin
        int   n0, a0;
        logic [5:0] held;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_letter = '0;
        bus.in_pos_l  = '0;
        bus.in_pos_m  = '0;
        bus.in_pos_r  = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_letter", bus.out_letter, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Directed letters with the latency check on
        chk_lat  = 1;
        last_out = '1;
        cyc(1, 0, 0, 0, 0, 1);
        drain();
        chk("dir_A_000", last_out, 3);
        last_out = '1;
        cyc(1, 0, 1, 0, 0, 1);
        drain();
        chk("dir_A_100", last_out, 10);
        last_out = '1;
        cyc(1, 30, rp(), rp(), rp(), 1);
        drain();
        chk("dir_oor_30", last_out, 30);

        // Back-to-back A..Z stream
        n0 = n_out;
        for (int i = 0; i < 26; i++) cyc(1, i, rp(), rp(), rp(), 1);
        drain();
        chk("stream_count", n_out - n0, 26);

        // Stall mid-stream
        chk_lat = 0;
        n0 = n_out;
        a0 = n_acc;
        held = '0;
        for (int i = 0; i < 8; i++) cyc(1, rp(), rp(), rp(), rp(), 1);
        for (int s = 0; s < 5; s++) begin
            cyc(1, rp(), rp(), rp(), rp(), 0);
            if (s == 0) held = s_ol;
            else chk("stall_stable", s_ol, held);
            chk("stall_vld", s_ovld, 1);
            chk("stall_in_ready", s_irdy, 0);
        end
        for (int i = 0; i < 6; i++) cyc(1, rp(), rp(), rp(), rp(), 1);
        drain();
        chk("stall_no_loss", n_out - n0, n_acc - a0);

        // Random valid/ready traffic including out-of-range letters
        n0 = n_out;
        a0 = n_acc;
        for (int i = 0; i < 300; i++)
            cyc(($urandom % 4) != 0, int'($urandom_range(0, 31)), rp(), rp(), rp(), ($urandom % 3) != 0);
        drain();
        chk("rand_no_loss", n_out - n0, n_acc - a0);

        // Reset with two letters in flight
        cyc(1, rp(), rp(), rp(), rp(), 1);
        cyc(1, rp(), rp(), rp(), rp(), 1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("pre_rst_vld", bus.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_out_letter", bus.out_letter, 0);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        n0 = n_out;
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 1);
        chk("post_rst_no_stale", n_out - n0, 0);
        chk_lat  = 1;
        last_out = '1;
        cyc(1, 0, 0, 0, 0, 1);
        drain();
        chk("post_rst_A_000", last_out, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
